// File: rtl/aes_pkg.sv
// =============================================================================
// aes_pkg : mode encodings and ShiftRows index helpers for the Rijndael state
// Revision: 1.0
// =============================================================================
`default_nettype none

package aes_pkg;

  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Rijndael uses a wider shift on rows 2 and 3 once the state reaches 8 columns.
  function automatic int unsigned shift_off(input int unsigned nb, input int unsigned row);
    int unsigned off;
    off = row;
    if (nb == 8 && row >= 2) off = row + 1;
    return off;
  endfunction

  function automatic int unsigned src_idx(input int unsigned nb, input logic [1:0] mode,
                                          input int unsigned k);
    int unsigned r;
    int unsigned c;
    int unsigned s;
    int unsigned idx;
    r   = k % 4;
    c   = k / 4;
    s   = shift_off(nb, r);
    idx = k;
    case (mode)
      MODE_FWD: idx = r + 4 * ((c + s) % nb);
      MODE_INV: idx = r + 4 * ((c + nb - s) % nb);
      default:  idx = k;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_shift_rows_pipe_if.sv
// =============================================================================
// aes_shift_rows_pipe_if : valid/ready block stream in and out of the unit
// Revision: 1.0
// =============================================================================
`default_nettype none

interface aes_shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  localparam int DATA_W = 32 * NB;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic [0:DATA_W-1] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:DATA_W-1] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

`default_nettype wire

// File: rtl/aes_sr_perm.sv
// =============================================================================
// aes_sr_perm : combinational NB-generic ShiftRows / InvShiftRows byte permutation
// Revision: 1.0
// =============================================================================
`default_nettype none

module aes_sr_perm
  import aes_pkg::*;
#(
  parameter  int NB     = 4,
  localparam int DATA_W = 32 * NB
) (
  input  logic [1:0]        mode,
  input  logic [0:DATA_W-1] in_data,
  output logic [0:DATA_W-1] out_data,
  output logic              err
);

  // Source indices are elaboration constants; only a 3-way byte mux is left at runtime.
  for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
    localparam int unsigned FWD_SRC = src_idx(NB, MODE_FWD, k);
    localparam int unsigned INV_SRC = src_idx(NB, MODE_INV, k);

    assign out_data[8*k +: 8] = (mode == MODE_FWD) ? in_data[8*FWD_SRC +: 8] :
                                (mode == MODE_INV) ? in_data[8*INV_SRC +: 8] :
                                                     in_data[8*k +: 8];
  end

  assign err = (mode == MODE_RSV);

endmodule

`default_nettype wire

// File: rtl/aes_shift_rows_pipe.sv
// =============================================================================
// aes_shift_rows_pipe : pipelined ShiftRows/InvShiftRows with valid/ready flow
// Revision: 1.0
// =============================================================================
`default_nettype none

module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int LAT   = 1,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_shift_rows_pipe_if.slave sr,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int DATA_W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("aes_shift_rows_pipe: LAT must be in 1..4");
  end

  logic [0:DATA_W-1] perm_data;
  logic              perm_err;

  aes_sr_perm #(.NB(NB)) u_perm (
    .mode     (sr.in_mode),
    .in_data  (sr.in_data),
    .out_data (perm_data),
    .err      (perm_err)
  );

  logic [LAT-1:0]    v_q, v_d;
  logic [LAT-1:0]    err_q, err_d;
  logic [TAG_W-1:0]  tag_q  [LAT];
  logic [TAG_W-1:0]  tag_d  [LAT];
  logic [0:DATA_W-1] data_q [LAT];
  logic [0:DATA_W-1] data_d [LAT];
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [LAT-1:0]    adv;
  logic              accept;

  // A stage moves when it, or any stage downstream of it, has a hole, or the sink takes.
  for (genvar i = 0; i < LAT; i++) begin : g_adv
    assign adv[i] = sr.out_ready | ~(&v_q[LAT-1:i]);
  end

  assign accept      = sr.in_valid & adv[0];
  assign sr.in_ready = adv[0];

  always_comb begin
    v_d       = v_q;
    err_d     = err_q;
    tag_d     = tag_q;
    data_d    = data_q;
    blk_cnt_d = blk_cnt_q;
    if (adv[0]) begin
      v_d[0] = accept;
      if (accept) begin
        err_d[0]  = perm_err;
        tag_d[0]  = sr.in_tag;
        data_d[0] = perm_data;
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
    for (int i = 1; i < LAT; i++) begin
      if (adv[i]) begin
        v_d[i]    = v_q[i-1];
        err_d[i]  = err_q[i-1];
        tag_d[i]  = tag_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      err_q     <= '0;
      blk_cnt_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      v_q       <= v_d;
      err_q     <= err_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign sr.out_valid = v_q[LAT-1];
  assign sr.out_err   = err_q[LAT-1];
  assign sr.out_tag   = tag_q[LAT-1];
  assign sr.out_data  = data_q[LAT-1];
  assign blk_cnt      = blk_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
// =============================================================================
// tb_aes_shift_rows_pipe : three configurations (NB4/LAT1, NB8/LAT3, NB6/LAT2)
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_aes_shift_rows_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt4, cnt8, cnt6;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  aes_shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
  aes_shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();
  aes_shift_rows_pipe_if #(.NB(6), .TAG_W(4)) b6 ();

  aes_shift_rows_pipe #(.NB(4), .LAT(1), .TAG_W(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .sr(b4), .blk_cnt(cnt4));
  aes_shift_rows_pipe #(.NB(8), .LAT(3), .TAG_W(4), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .sr(b8), .blk_cnt(cnt8));
  aes_shift_rows_pipe #(.NB(6), .LAT(2), .TAG_W(4), .CNT_W(16)) u6 (
    .clk(clk), .rst_n(rst_n), .sr(b6), .blk_cnt(cnt6));

  // Reference: lay the bytes out as a 4 x nb matrix and rotate each row one column at a time.
  function automatic logic [0:255] sr_model(input int nb, input logic [1:0] mode,
                                             input logic [0:255] din);
    logic [7:0]   m [4][8];
    logic [7:0]   t;
    logic [0:255] r;
    int           s;
    r = din;
    if (mode[1]) return din;
    for (int k = 0; k < 4 * nb; k++) m[k % 4][k / 4] = din[8*k +: 8];
    for (int row = 0; row < 4; row++) begin
      s = (nb == 8 && row >= 2) ? row + 1 : row;
      repeat (s) begin
        if (mode == 2'b00) begin
          t = m[row][0];
          for (int c = 0; c < nb - 1; c++) m[row][c] = m[row][c+1];
          m[row][nb-1] = t;
        end else begin
          t = m[row][nb-1];
          for (int c = nb - 1; c > 0; c--) m[row][c] = m[row][c-1];
          m[row][0] = t;
        end
      end
    end
    for (int k = 0; k < 4 * nb; k++) r[8*k +: 8] = m[k % 4][k / 4];
    return r;
  endfunction

  task automatic idle_all();
    b4.in_valid = 0; b4.in_mode = 0; b4.in_tag = 0; b4.in_data = '0; b4.out_ready = 1;
    b8.in_valid = 0; b8.in_mode = 0; b8.in_tag = 0; b8.in_data = '0; b8.out_ready = 1;
    b6.in_valid = 0; b6.in_mode = 0; b6.in_tag = 0; b6.in_data = '0; b6.out_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", b4.out_valid); end
    n_checks++; if (b4.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got=%b want=0", b4.out_err); end
    n_checks++; if (b4.out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", b4.out_data); end
    n_checks++; if (b4.out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", b4.out_tag); end
    n_checks++; if (cnt4 !== 16'd0) begin n_fail++; $display("FAIL reset_blk_cnt got=%0d want=0", cnt4); end
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nb8_valid got=%b want=0", b8.out_valid); end
    rst_n = 1;
    b4.out_ready = 0; b8.out_ready = 0; b6.out_ready = 0;
    #1;
    n_checks++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4 got=%b want=1", b4.in_ready); end
    n_checks++; if (b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got=%b want=1", b8.in_ready); end
    n_checks++; if (b6.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready6 got=%b want=1", b6.in_ready); end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_inverse_nb4();
    logic [0:127] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    b4.in_valid = 1; b4.in_mode = 2'b01; b4.in_tag = 4'h2; b4.in_data = d; b4.out_ready = 1;
    @(posedge clk); #1;
    b4.in_valid = 0;
    n_checks++; if (b4.out_valid !== 1'b1) begin n_fail++; $display("FAIL inv4_valid got=%b want=1", b4.out_valid); end
    n_checks++; if (b4.out_data !== 128'h000d0a07_04010e0b_0805020f_0c090603) begin n_fail++; $display("FAIL inv4_data got=%h want=000d0a0704010e0b0805020f0c090603", b4.out_data); end
    n_checks++; if (cnt4 !== 16'd1) begin n_fail++; $display("FAIL inv4_blk_cnt got=%0d want=1", cnt4); end
    @(posedge clk); #1;
  endtask

  task automatic test_forward_roundtrip();
    logic [0:127] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    b4.in_valid = 1; b4.in_mode = 2'b00; b4.in_data = d;
    @(posedge clk); #1;
    n_checks++; if (b4.out_data !== 128'h00050a0f_04090e03_080d0207_0c01060b) begin n_fail++; $display("FAIL fwd4_data got=%h want=00050a0f04090e03080d02070c01060b", b4.out_data); end
    b4.in_mode = 2'b01; b4.in_data = b4.out_data;
    @(posedge clk); #1;
    b4.in_valid = 0;
    n_checks++; if (b4.out_data !== 128'h00010203_04050607_08090a0b_0c0d0e0f) begin n_fail++; $display("FAIL roundtrip4_data got=%h want=000102030405060708090a0b0c0d0e0f", b4.out_data); end
    n_checks++; if (cnt4 !== 16'd3) begin n_fail++; $display("FAIL roundtrip4_blk_cnt got=%0d want=3", cnt4); end
    @(posedge clk); #1;
  endtask

  task automatic test_nb8_lat3();
    logic [0:255] d;
    logic [0:255] o;
    logic [0:255] e;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k);
    e = sr_model(8, 2'b00, d);
    b8.in_valid = 1; b8.in_mode = 2'b00; b8.in_tag = 4'h9; b8.in_data = d; b8.out_ready = 1;
    @(posedge clk); #1;
    b8.in_valid = 0;
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL nb8_early_valid1 got=%b want=0", b8.out_valid); end
    @(posedge clk); #1;
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL nb8_early_valid2 got=%b want=0", b8.out_valid); end
    @(posedge clk); #1;
    o = b8.out_data;
    n_checks++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL nb8_lat3_valid got=%b want=1", b8.out_valid); end
    n_checks++; if (o[16 +: 8] !== 8'h0e) begin n_fail++; $display("FAIL nb8_byte2 got=%h want=0e", o[16 +: 8]); end
    n_checks++; if (o[24 +: 8] !== 8'h13) begin n_fail++; $display("FAIL nb8_byte3 got=%h want=13", o[24 +: 8]); end
    n_checks++; if (o[248 +: 8] !== 8'h0f) begin n_fail++; $display("FAIL nb8_byte31 got=%h want=0f", o[248 +: 8]); end
    n_checks++; if (o !== e) begin n_fail++; $display("FAIL nb8_full got=%h want=%h", o, e); end
    n_checks++; if (b8.out_tag !== 4'h9) begin n_fail++; $display("FAIL nb8_tag got=%h want=9", b8.out_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [0:127] d;
    logic [0:255] e;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
    b4.in_valid = 1; b4.in_mode = 2'b10; b4.in_tag = 4'h3; b4.in_data = d;
    @(posedge clk); #1;
    n_checks++; if (b4.out_data !== d) begin n_fail++; $display("FAIL bypass_data got=%h want=%h", b4.out_data, d); end
    n_checks++; if (b4.out_err !== 1'b0) begin n_fail++; $display("FAIL bypass_err got=%b want=0", b4.out_err); end
    b4.in_mode = 2'b11; b4.in_tag = 4'h7;
    @(posedge clk); #1;
    n_checks++; if (b4.out_data !== d) begin n_fail++; $display("FAIL rsv_data got=%h want=%h", b4.out_data, d); end
    n_checks++; if (b4.out_err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got=%b want=1", b4.out_err); end
    n_checks++; if (b4.out_tag !== 4'h7) begin n_fail++; $display("FAIL rsv_tag got=%h want=7", b4.out_tag); end
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
      b4.in_mode = 2'(n % 2); b4.in_data = d;
      e = sr_model(4, 2'(n % 2), {d, 128'h0});
      @(posedge clk); #1;
      n_checks++; if (b4.out_data !== e[0:127]) begin n_fail++; $display("FAIL rand4_data mode=%0d got=%h want=%h", n % 2, b4.out_data, e[0:127]); end
    end
    b4.in_valid = 0;
    @(posedge clk); #1;
  endtask

  // Streams blocks through the NB=6/LAT=2 unit; the pipe is empty on entry.
  task automatic test_back_to_back(input int nblk, input bit pattern);
    logic [0:255] exp_q [$];
    logic [3:0]   tag_q [$];
    logic         err_q [$];
    logic [0:191] d;
    logic [0:191] held;
    logic [3:0]   held_tag;
    logic [0:255] e;
    logic [3:0]   et;
    logic         ee;
    logic [1:0]   md;
    bit           stalled = 0;
    int           sent = 0, rcvd = 0, occ = 0, cyc = 0;
    while (rcvd < nblk && cyc < 600) begin
      if (stalled) begin
        n_checks++; if (b6.out_valid !== 1'b1 || b6.out_data !== held || b6.out_tag !== held_tag) begin
          n_fail++; $display("FAIL stall_hold got=%b/%h/%h want=1/%h/%h", b6.out_valid, b6.out_tag, b6.out_data, held_tag, held);
        end
      end
      b6.out_ready = pattern ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      b6.in_valid  = (sent < nblk) && (pattern || $urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) d[32*i +: 32] = $urandom();
      md = pattern ? 2'(sent % 3) : 2'($urandom_range(0, 3));
      b6.in_mode = md; b6.in_tag = 4'(sent); b6.in_data = d;
      #1;
      n_checks++; if (b6.in_ready !== !(occ == 2 && !b6.out_ready)) begin
        n_fail++; $display("FAIL in_ready got=%b want=%b occ=%0d", b6.in_ready, !(occ == 2 && !b6.out_ready), occ);
      end
      if (b6.out_valid && b6.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL spurious_block got=tag%h want=none", b6.out_tag);
        end else begin
          e = exp_q.pop_front(); et = tag_q.pop_front(); ee = err_q.pop_front();
          n_checks++; if (b6.out_data !== e[0:191] || b6.out_tag !== et || b6.out_err !== ee) begin
            n_fail++; $display("FAIL stream_block got=%h/%h/%b want=%h/%h/%b", b6.out_tag, b6.out_data, b6.out_err, et, e[0:191], ee);
          end
        end
        rcvd++; occ--;
      end
      stalled = b6.out_valid && !b6.out_ready;
      held = b6.out_data; held_tag = b6.out_tag;
      if (b6.in_valid && b6.in_ready) begin
        exp_q.push_back(sr_model(6, md, {d, 64'h0}));
        tag_q.push_back(4'(sent)); err_q.push_back(md == 2'b11);
        sent++; occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (rcvd !== nblk) begin n_fail++; $display("FAIL stream_count got=%0d want=%0d", rcvd, nblk); end
    b6.in_valid = 0; b6.out_ready = 1;
  endtask

  task automatic test_reset_mid();
    logic [0:191] d;
    logic [0:255] e;
    b6.out_ready = 0;
    b6.in_valid = 1; b6.in_mode = 2'b00; b6.in_tag = 4'h1; b6.in_data = {6{32'hdeadbeef}};
    @(posedge clk); #1;
    b6.in_tag = 4'h2;
    @(posedge clk); #1;
    b6.in_valid = 0;
    #1 rst_n = 0;
    #1;
    n_checks++; if (b6.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b want=0", b6.out_valid); end
    n_checks++; if (cnt6 !== 16'd0) begin n_fail++; $display("FAIL midrst_blk_cnt got=%0d want=0", cnt6); end
    n_checks++; if (b6.out_tag !== 4'h0 || b6.out_data !== '0) begin n_fail++; $display("FAIL midrst_out got=%h/%h want=0/0", b6.out_tag, b6.out_data); end
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    n_checks++; if (b6.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", b6.in_ready); end
    for (int i = 0; i < 6; i++) d[32*i +: 32] = $urandom();
    e = sr_model(6, 2'b01, {d, 64'h0});
    b6.out_ready = 1; b6.in_valid = 1; b6.in_mode = 2'b01; b6.in_tag = 4'h5; b6.in_data = d;
    @(posedge clk); #1;
    b6.in_valid = 0;
    n_checks++; if (b6.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early got=%b want=0", b6.out_valid); end
    @(posedge clk); #1;
    n_checks++; if (b6.out_valid !== 1'b1 || b6.out_data !== e[0:191] || b6.out_tag !== 4'h5) begin
      n_fail++; $display("FAIL midrst_block got=%b/%h/%h want=1/5/%h", b6.out_valid, b6.out_tag, b6.out_data, e[0:191]);
    end
    n_checks++; if (cnt6 !== 16'd1) begin n_fail++; $display("FAIL midrst_cnt_after got=%0d want=1", cnt6); end
  endtask

  initial begin
    test_reset();
    test_inverse_nb4();
    test_forward_roundtrip();
    test_nb8_lat3();
    test_modes();
    test_back_to_back(6, 1'b1);
    test_back_to_back(40, 1'b0);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows/InvShiftRows unit for the AES/Rijndael datapath.
- Supports block widths Nb = 4, 6 and 8 words (Rijndael offsets).
- Forward, inverse or bypass is selected per transaction, so one instance serves both the encrypt and decrypt round loops.
- Valid/ready handshake with back-pressure, a configurable pipeline latency, a pass-through tag for round/ID tracking, and a block counter.

Parameters:
- NB, 4, state columns (legal values 4, 6, 8). DATA_W = 32*NB.
- LAT, 1, pipeline stages from accept to output (legal 1..4).
- TAG_W, 4, width of the sideband tag carried alongside the data (1..8).
- CNT_W, 16, width of the wrapping accepted-block counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept this cycle.
- in_mode  in  2  00 forward, 01 inverse, 10 bypass, 11 reserved.
- in_tag  in  TAG_W  sideband, returned unchanged.
- in_data  in  DATA_W  state in, declared [0:DATA_W-1].
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  transformed state, [0:DATA_W-1].
- out_tag  out  TAG_W  tag of the output block.
- out_err  out  1  the block was issued with mode 11.
- blk_cnt  out  CNT_W  count of accepted blocks, wraps.

Behaviour:
- Byte k occupies bits [8k:8k+7], with bit 0 the MSB of byte 0. The layout is column-major: row r = k mod 4, column c = k div 4.
- Shift offsets: s = {0,1,2,3} for NB=4 and 6; s = {0,1,3,4} for NB=8.
- Forward: out[r+4c] = in[r+4((c+s[r]) mod NB)].
- Inverse: out[r+4c] = in[r+4((c-s[r]+NB) mod NB)].
- Bypass, and mode 11: out = in. For mode 11 the err bit is set and travels with the block.
- The permutation is combinational between the in_* ports and the stage-0 register. Stages 1..LAT-1 are pure delay. Each stage holds {v, mode-err, tag, data}.
- Stage i advances when v[i]=0 or stage i+1 advances. The last stage advances when out_valid is low or out_ready is high.
- in_ready = advance of stage 0. It is combinational from out_ready through the chain, with no registered bubble.
- Accept occurs when in_valid && in_ready. On accept, stage 0 loads, and blk_cnt increments mod 2^CNT_W.
- When stage 0 advances without an accept, v[0] clears and the data is left don't-care (not reloaded).
- Latency: an accept at edge T gives out_valid high after edge T+LAT-1, i.e. visible in the cycle following the LAT-th edge, counting the accepting edge. With out_ready held high, throughput is 1 block/cycle.
- Outputs: out_valid = v[LAT-1]. out_data, out_tag and out_err come from the last stage.
- While out_valid && !out_ready, out_data, out_tag and out_err are held stable.
- No block is dropped or duplicated under any in_valid/out_ready pattern. Blocks emerge in order.
- Simultaneous accept and emit in a full pipeline is legal: the chain shifts by one.
- Reset: asserting rst_n low at any time, including mid-transfer, clears every v to 0 and blk_cnt to 0.
  - out_valid is 0 and out_err is 0 during reset. out_data and out_tag are reset to 0.
  - in_ready is 1 after reset, since all stages are empty.
  - In-flight blocks are discarded.
- An illegal NB or LAT is caught by an elaboration-time check that stops compilation.

Decomposition:
- Package aes_pkg holds:
  - mode encodings: MODE_FWD=2'b00, MODE_INV=2'b01, MODE_BYP=2'b10, MODE_RSV=2'b11;
  - a function returning the shift offset for (NB, row);
  - a function computing the source byte index for (NB, mode, k).
- One natural sub-module, aes_sr_perm. It is a purely combinational NB-generic byte permutation with inputs mode and data and outputs permuted data and err. It is instantiated at stage 0.
- The pipeline/handshake logic lives in the top level.

Test Plan:
- NB=4, LAT=1, inverse, in bytes 00..0f, out_ready=1 -> out bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03 one cycle after accept; blk_cnt=1.
- NB=4, forward, same input -> 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. Then feed that output back with inverse -> 00..0f restored.
- NB=8, LAT=3, forward, bytes 00..1f -> out byte 2 = 0e, byte 3 = 13, byte 31 = 0f; latency exactly 3.
- Back-pressure, LAT=2: stream 6 blocks with tags 0..5 while out_ready toggles 1,0,0,1,... -> all 6 emerge in order, data stable while stalled, in_ready low only when both stages are full and out_ready=0.
- Mode 10 -> out = in, err=0. Mode 11 with tag 7 -> out = in, out_err=1, out_tag=7.
- Reset mid-stream: rst_n low with 2 blocks in flight -> out_valid=0 immediately, blk_cnt=0, in_ready=1 after release, next accepted block emerges with correct data.
